// File: rtl/mac_cfg_pkg.sv
// mac_cfg_pkg: register indices, FSM states, AXI response codes and address/boot helpers for mac_cfg_sequencer
package mac_cfg_pkg;
  localparam logic [2:0] HOST_MAC_BASE = 3'd0;
  localparam logic [2:0] HOST_MAC_HI   = 3'd1;
  localparam logic [2:0] DEV_MAC_BASE  = 3'd2;
  localparam logic [2:0] DEV_MAC_HI    = 3'd3;
  localparam logic [2:0] DOCE_MAC_BASE = 3'd4;
  localparam logic [2:0] DOCE_MAC_HI   = 3'd5;
  localparam logic [2:0] DOCE_IP       = 3'd6;
  localparam logic [2:0] BAD_IDX       = 3'd7;
  localparam logic [1:0] AXI_OKAY      = 2'b00;

  typedef enum logic [3:0] {
    ST_BOOT, ST_WR_REQ, ST_WR_RSP, ST_ARB, ST_RD_AR, ST_RD_R, ST_RESP
`ifdef MAC_CFG_READBACK_VERIFY_EN
    , ST_VFY_AR, ST_VFY_R
`endif
  } state_t;

  function automatic logic [31:0] reg_addr(input logic [31:0] base, input logic [2:0] idx);
    return base + {27'd0, idx, 2'b00};
  endfunction

  function automatic logic [31:0] boot_word(input logic [2:0] idx, input logic [47:0] host,
                                            input logic [47:0] dev, input logic [47:0] doce,
                                            input logic [31:0] ip);
    return idx == HOST_MAC_BASE ? host[31:0] : idx == HOST_MAC_HI ? {16'h0, host[47:32]} :
           idx == DEV_MAC_BASE  ? dev[31:0]  : idx == DEV_MAC_HI  ? {16'h0, dev[47:32]}  :
           idx == DOCE_MAC_BASE ? doce[31:0] : idx == DOCE_MAC_HI ? {16'h0, doce[47:32]} :
           idx == DOCE_IP       ? ip         : 32'h0;
  endfunction
endpackage

// File: rtl/mac_cfg_if.sv
// mac_cfg_if: AXI-Lite bus between the config sequencer (master) and the register bank (slave)
interface mac_cfg_if;
  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic        wvalid, wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid, bready;
  logic [1:0]  bresp;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic        rvalid, rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  modport master(output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
                 input awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp);
  modport slave(input awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
                output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp);
endinterface

// File: rtl/mac_cfg_rr_arb.sv
// mac_cfg_rr_arb: 2-way round-robin arbiter; pointer hands priority to the other requester after each accepted grant
module mac_cfg_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_valid,
  input  logic       i_accept,
  output logic [1:0] o_gnt
);
  logic r_ptr;
  assign o_gnt = &i_valid ? (r_ptr ? 2'b10 : 2'b01) : i_valid;
  always_ff @(posedge clk)
    if (rst) r_ptr <= 1'b0;
    else if (i_accept && |o_gnt) r_ptr <= o_gnt[0];
endmodule

// File: rtl/mac_cfg_sequencer.sv
// mac_cfg_sequencer: AXI-Lite master that boots the MAC/IP register bank, then serves two requesters round-robin.
// Define MAC_CFG_READBACK_VERIFY_EN to read back and compare every write.
module mac_cfg_sequencer import mac_cfg_pkg::*; #(
  parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
  parameter logic [47:0] INIT_HOST_MAC = 48'hEEA0_DDCCBBAA,
  parameter logic [47:0] INIT_DEV_MAC  = 48'hEEB0_DDCCBBAA,
  parameter logic [47:0] INIT_DOCE_MAC = 48'hEEC0_DDCCBBAA,
  parameter logic [31:0] INIT_IP       = 32'h0101_0101
) (
  input  logic        axi_lite_aclk,
  input  logic        axi_lite_areset,
  mac_cfg_if.master   m_axi_lite,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_wr,
  input  logic [2:0]  req0_idx,
  input  logic [31:0] req0_wdata,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_rdata,
  output logic        rsp0_err,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_wr,
  input  logic [2:0]  req1_idx,
  input  logic [31:0] req1_wdata,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_rdata,
  output logic        rsp1_err,
  output logic        boot_done,
  output logic        cfg_err
);
  state_t           r_state;
  logic [2:0]       r_boot_idx;
  logic             r_boot_done, r_cfg_err, r_owner, r_err;
  logic [31:0]      r_wdata, r_rdata, r_awaddr, r_araddr;
  logic             r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
  logic [1:0]       r_req_ready, r_rsp_valid, r_rsp_err;
  logic [1:0][31:0] r_rsp_rdata;
  logic [1:0]       w_gnt, w_req_valid, w_rsp_ready;
  logic             w_gnt_sel, w_gnt_wr, w_wr_done, w_wr_err;
  logic [2:0]       w_gnt_idx;
  logic [31:0]      w_gnt_wdata;

  assign w_req_valid = {req1_valid, req0_valid};
  assign w_rsp_ready = {rsp1_ready, rsp0_ready};
  assign w_gnt_sel   = w_gnt[1];
  assign w_gnt_wr    = w_gnt_sel ? req1_wr : req0_wr;
  assign w_gnt_idx   = w_gnt_sel ? req1_idx : req0_idx;
  assign w_gnt_wdata = w_gnt_sel ? req1_wdata : req0_wdata;

  mac_cfg_rr_arb u_arb (
    .clk      (axi_lite_aclk),
    .rst      (axi_lite_areset),
    .i_valid  (w_req_valid),
    .i_accept (r_state == ST_ARB),
    .o_gnt    (w_gnt)
  );

  // A write is finished once its last bus phase completes: bresp, or the readback when verifying.
`ifdef MAC_CFG_READBACK_VERIFY_EN
  assign w_wr_done = r_state == ST_VFY_R && m_axi_lite.rvalid;
  assign w_wr_err  = r_err || m_axi_lite.rresp != AXI_OKAY || m_axi_lite.rdata != r_wdata;
`else
  assign w_wr_done = r_state == ST_WR_RSP && m_axi_lite.bvalid;
  assign w_wr_err  = r_err || m_axi_lite.bresp != AXI_OKAY;
`endif

  always_ff @(posedge axi_lite_aclk) begin
    if (axi_lite_areset) begin
      r_state     <= ST_BOOT;
      r_boot_idx  <= 3'd0;
      r_boot_done <= 1'b0;
      r_cfg_err   <= 1'b0;
      r_owner     <= 1'b0;
      r_err       <= 1'b0;
      r_wdata     <= 32'h0;
      r_rdata     <= 32'h0;
      r_awaddr    <= 32'h0;
      r_araddr    <= 32'h0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_req_ready <= 2'b00;
      r_rsp_valid <= 2'b00;
      r_rsp_err   <= 2'b00;
      r_rsp_rdata <= '0;
    end else begin
      r_req_ready <= 2'b00;
      case (r_state)
        ST_BOOT: begin
          r_wdata   <= boot_word(r_boot_idx, INIT_HOST_MAC, INIT_DEV_MAC, INIT_DOCE_MAC, INIT_IP);
          r_awaddr  <= reg_addr(BASE_ADDR, r_boot_idx);
          r_awvalid <= 1'b1;
          r_wvalid  <= 1'b1;
          r_state   <= ST_WR_REQ;
        end
        ST_ARB: if (|w_gnt) begin
          r_req_ready <= w_gnt;
          r_owner     <= w_gnt_sel;
          r_wdata     <= w_gnt_wdata;
          r_rdata     <= 32'h0;
          r_err       <= 1'b0;
          if (w_gnt_idx == BAD_IDX) begin
            r_err   <= 1'b1;
            r_state <= ST_RESP;
          end else if (w_gnt_wr) begin
            r_awaddr  <= reg_addr(BASE_ADDR, w_gnt_idx);
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_state   <= ST_WR_REQ;
          end else begin
            r_araddr  <= reg_addr(BASE_ADDR, w_gnt_idx);
            r_arvalid <= 1'b1;
            r_state   <= ST_RD_AR;
          end
        end
        ST_WR_REQ: begin
          if (m_axi_lite.awready) r_awvalid <= 1'b0;
          if (m_axi_lite.wready) r_wvalid <= 1'b0;
          if ((!r_awvalid || m_axi_lite.awready) && (!r_wvalid || m_axi_lite.wready)) begin
            r_bready <= 1'b1;
            r_state  <= ST_WR_RSP;
          end
        end
        ST_WR_RSP: if (m_axi_lite.bvalid) begin
          r_bready <= 1'b0;
`ifdef MAC_CFG_READBACK_VERIFY_EN
          r_err     <= r_err || m_axi_lite.bresp != AXI_OKAY;
          r_araddr  <= r_awaddr;
          r_arvalid <= 1'b1;
          r_state   <= ST_VFY_AR;
`endif
        end
        ST_RD_AR: if (m_axi_lite.arready) begin
          r_arvalid <= 1'b0;
          r_rready  <= 1'b1;
          r_state   <= ST_RD_R;
        end
        ST_RD_R: if (m_axi_lite.rvalid) begin
          r_rready <= 1'b0;
          r_rdata  <= m_axi_lite.rdata;
          r_err    <= r_err || m_axi_lite.rresp != AXI_OKAY;
          r_state  <= ST_RESP;
        end
`ifdef MAC_CFG_READBACK_VERIFY_EN
        ST_VFY_AR: if (m_axi_lite.arready) begin
          r_arvalid <= 1'b0;
          r_rready  <= 1'b1;
          r_state   <= ST_VFY_R;
        end
        ST_VFY_R: if (m_axi_lite.rvalid) r_rready <= 1'b0;
`endif
        ST_RESP:
          if (r_rsp_valid == 2'b00) begin
            r_rsp_valid[r_owner] <= 1'b1;
            r_rsp_rdata[r_owner] <= r_rdata;
            r_rsp_err[r_owner]   <= r_err;
            r_cfg_err            <= r_cfg_err || r_err;
          end else if (|(r_rsp_valid & w_rsp_ready)) begin
            r_rsp_valid <= 2'b00;
            r_state     <= ST_ARB;
          end
        default: r_state <= ST_BOOT;
      endcase
      // Boot errors only raise the sticky flag; requester errors travel back in the response.
      if (w_wr_done) begin
        if (r_boot_done) begin
          r_err   <= w_wr_err;
          r_state <= ST_RESP;
        end else begin
          r_cfg_err   <= r_cfg_err || w_wr_err;
          r_err       <= 1'b0;
          r_boot_done <= r_boot_idx == DOCE_IP;
          r_boot_idx  <= r_boot_idx + 3'd1;
          r_state     <= r_boot_idx == DOCE_IP ? ST_ARB : ST_BOOT;
        end
      end
    end
  end

  assign m_axi_lite.awvalid = r_awvalid;
  assign m_axi_lite.awaddr  = r_awaddr;
  assign m_axi_lite.wvalid  = r_wvalid;
  assign m_axi_lite.wdata   = r_wdata;
  assign m_axi_lite.wstrb   = 4'hF;
  assign m_axi_lite.bready  = r_bready;
  assign m_axi_lite.arvalid = r_arvalid;
  assign m_axi_lite.araddr  = r_araddr;
  assign m_axi_lite.rready  = r_rready;
  assign req0_ready = r_req_ready[0];
  assign req1_ready = r_req_ready[1];
  assign rsp0_valid = r_rsp_valid[0];
  assign rsp1_valid = r_rsp_valid[1];
  assign rsp0_rdata = r_rsp_rdata[0];
  assign rsp1_rdata = r_rsp_rdata[1];
  assign rsp0_err   = r_rsp_err[0];
  assign rsp1_err   = r_rsp_err[1];
  assign boot_done  = r_boot_done;
  assign cfg_err    = r_cfg_err;
endmodule

// File: tb/tb_mac_cfg_sequencer.sv
// tb_mac_cfg_sequencer: directed bench for mac_cfg_sequencer with a configurable AXI-Lite register-bank model
module tb_mac_cfg_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mac_cfg_if axi();
  logic [1:0]  req_valid = 2'b00, req_wr = 2'b00, rsp_ready = 2'b00;
  logic [1:0]  req_ready, rsp_valid, rsp_err;
  logic [2:0]  req_idx [2] = '{3'd0, 3'd0};
  logic [31:0] req_wdata [2] = '{32'h0, 32'h0};
  logic [31:0] rsp_rdata [2];
  logic        boot_done, cfg_err;
  int tests = 0;
  int fails = 0;

  mac_cfg_sequencer dut (
    .axi_lite_aclk(clk), .axi_lite_areset(rst), .m_axi_lite(axi.master),
    .req0_valid(req_valid[0]), .req0_ready(req_ready[0]), .req0_wr(req_wr[0]),
    .req0_idx(req_idx[0]), .req0_wdata(req_wdata[0]), .rsp0_valid(rsp_valid[0]),
    .rsp0_ready(rsp_ready[0]), .rsp0_rdata(rsp_rdata[0]), .rsp0_err(rsp_err[0]),
    .req1_valid(req_valid[1]), .req1_ready(req_ready[1]), .req1_wr(req_wr[1]),
    .req1_idx(req_idx[1]), .req1_wdata(req_wdata[1]), .rsp1_valid(rsp_valid[1]),
    .rsp1_ready(rsp_ready[1]), .rsp1_rdata(rsp_rdata[1]), .rsp1_err(rsp_err[1]),
    .boot_done(boot_done), .cfg_err(cfg_err)
  );

  // Register-bank model: programmable aw/w ready delays, bresp and readback corruption.
  int          aw_dly = 0, w_dly = 0, aw_wait = 0, w_wait = 0, aw_cnt = 0, ar_cnt = 0;
  logic [1:0]  bresp_cfg = 2'b00;
  logic        corrupt = 1'b0, aw_got = 1'b0, w_got = 1'b0;
  logic [31:0] aw_a = 32'h0, w_d = 32'h0;
  logic [31:0] mem [8];
  logic [31:0] log_addr [$];
  logic [31:0] log_data [$];
  assign axi.awready = axi.awvalid && (aw_wait >= aw_dly);
  assign axi.wready  = axi.wvalid && (w_wait >= w_dly);
  assign axi.arready = axi.arvalid;
  always @(posedge clk) begin
    if (rst) begin
      aw_wait <= 0; w_wait <= 0; aw_got <= 1'b0; w_got <= 1'b0;
      axi.bvalid <= 1'b0; axi.bresp <= 2'b00;
      axi.rvalid <= 1'b0; axi.rdata <= 32'h0; axi.rresp <= 2'b00;
    end else begin
      if (axi.awvalid && axi.awready) begin
        aw_got <= 1'b1; aw_a <= axi.awaddr; aw_wait <= 0; aw_cnt <= aw_cnt + 1;
      end else if (axi.awvalid) aw_wait <= aw_wait + 1;
      if (axi.wvalid && axi.wready) begin
        w_got <= 1'b1; w_d <= axi.wdata; w_wait <= 0;
      end else if (axi.wvalid) w_wait <= w_wait + 1;
      if (aw_got && w_got && !axi.bvalid) begin
        axi.bvalid <= 1'b1; axi.bresp <= bresp_cfg;
        mem[aw_a[4:2]] <= w_d;
        log_addr.push_back(aw_a); log_data.push_back(w_d);
        aw_got <= 1'b0; w_got <= 1'b0;
      end else if (axi.bvalid && axi.bready) axi.bvalid <= 1'b0;
      if (axi.arvalid && axi.arready) begin
        axi.rvalid <= 1'b1; axi.rresp <= 2'b00; ar_cnt <= ar_cnt + 1;
        axi.rdata <= mem[axi.araddr[4:2]] ^ {31'd0, corrupt};
      end else if (axi.rvalid && axi.rready) axi.rvalid <= 1'b0;
    end
  end

  task automatic do_req(input int n, input logic wr, input logic [2:0] idx, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output logic ok);
    int t;
    ok = 1'b0; rd = 32'hX; er = 1'bX;
    req_wr[n] = wr; req_idx[n] = idx; req_wdata[n] = wd; req_valid[n] = 1'b1;
    t = 0;
    while (!req_ready[n] && t < 50) begin @(negedge clk); t++; end
    req_valid[n] = 1'b0;
    if (t >= 50) return;
    t = 0;
    while (!rsp_valid[n] && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) return;
    rd = rsp_rdata[n]; er = rsp_err[n]; ok = 1'b1;
    rsp_ready[n] = 1'b1;
    @(negedge clk);
    rsp_ready[n] = 1'b0;
  endtask

  task automatic test_reset;
    logic [12:0]  ctl;
    logic [159:0] dat;
    repeat (2) @(negedge clk);
    ctl = {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready, req_ready, rsp_valid, rsp_err, boot_done, cfg_err};
    dat = {axi.awaddr, axi.araddr, axi.wdata, rsp_rdata[0], rsp_rdata[1]};
    tests++; if (ctl !== 13'd0) begin fails++; $display("FAIL reset_ctl: got %h want 0", ctl); end
    tests++; if (dat !== 160'd0) begin fails++; $display("FAIL reset_data: got %h want 0", dat); end
    tests++; if (axi.wstrb !== 4'hF) begin fails++; $display("FAIL reset_wstrb: got %h want f", axi.wstrb); end
    rst = 1'b0;
  endtask

  task automatic test_boot;
    logic [31:0] exp_d [7] = '{32'hDDCCBBAA, 32'h0000EEA0, 32'hDDCCBBAA, 32'h0000EEB0,
                               32'hDDCCBBAA, 32'h0000EEC0, 32'h01010101};
    int t = 0;
    while (!boot_done && t < 300) begin @(negedge clk); t++; end
    tests++; if (boot_done !== 1'b1) begin fails++; $display("FAIL boot_done: got %b want 1", boot_done); end
    tests++; if (log_addr.size() != 7) begin fails++; $display("FAIL boot_count: got %0d want 7", log_addr.size()); end
    for (int i = 0; i < 7 && i < log_addr.size(); i++) begin
      tests++;
      if (log_addr[i] !== 32'(i * 4) || log_data[i] !== exp_d[i]) begin
        fails++; $display("FAIL boot_wr%0d: got %h/%h want %h/%h", i, log_addr[i], log_data[i], 32'(i * 4), exp_d[i]);
      end
    end
    tests++; if (cfg_err !== 1'b0) begin fails++; $display("FAIL boot_cfg_err: got %b want 0", cfg_err); end
  endtask

  task automatic test_write_read;
    logic [31:0] rd; logic er, ok;
    do_req(0, 1'b1, 3'd6, 32'hC0A80001, rd, er, ok);
    tests++; if ({ok, er, rd} !== {1'b1, 1'b0, 32'h0}) begin fails++; $display("FAIL wr0: got ok=%b err=%b rdata=%h want ok=1 err=0 rdata=0", ok, er, rd); end
    do_req(1, 1'b0, 3'd6, 32'h0, rd, er, ok);
    tests++; if ({ok, er, rd} !== {1'b1, 1'b0, 32'hC0A80001}) begin fails++; $display("FAIL rd1: got ok=%b err=%b rdata=%h want ok=1 err=0 rdata=c0a80001", ok, er, rd); end
  endtask

  task automatic test_back_to_back;
    int order [$];
    int served [2] = '{0, 0};
    int exp_o [4] = '{0, 1, 0, 1};
    logic [31:0] exp_rd [2] = '{32'hDDCCBBAA, 32'hDDCCBBAA};
    int bad_rd = 0;
    int t = 0;
    req_wr = 2'b00; req_idx[0] = 3'd0; req_idx[1] = 3'd2; req_valid = 2'b11;
    while ((served[0] < 2 || served[1] < 2) && t < 200) begin
      @(negedge clk); t++;
      for (int n = 0; n < 2; n++) begin
        if (req_ready[n]) begin order.push_back(n); req_valid[n] = 1'b0; end
        if (rsp_valid[n] && !rsp_ready[n]) begin
          if (rsp_rdata[n] !== exp_rd[n] || rsp_err[n] !== 1'b0) bad_rd++;
          rsp_ready[n] = 1'b1; served[n]++;
          if (served[n] < 2) req_valid[n] = 1'b1;
        end else rsp_ready[n] = 1'b0;
      end
    end
    @(negedge clk); rsp_ready = 2'b00; req_valid = 2'b00;
    tests++; if (order.size() != 4) begin fails++; $display("FAIL b2b_grants: got %0d want 4", order.size()); end
    for (int i = 0; i < 4 && i < order.size(); i++) begin
      tests++; if (order[i] != exp_o[i]) begin fails++; $display("FAIL b2b_order%0d: got %0d want %0d", i, order[i], exp_o[i]); end
    end
    tests++; if (bad_rd != 0) begin fails++; $display("FAIL b2b_rdata: got %0d bad responses want 0", bad_rd); end
  endtask

  task automatic test_bad_idx;
    logic [31:0] rd; logic er, ok;
    int aw0 = aw_cnt, ar0 = ar_cnt;
    do_req(1, 1'b0, 3'd7, 32'h0, rd, er, ok);
    tests++; if ({ok, er, rd} !== {1'b1, 1'b1, 32'h0}) begin fails++; $display("FAIL bad_idx_rsp: got ok=%b err=%b rdata=%h want ok=1 err=1 rdata=0", ok, er, rd); end
    tests++; if (aw_cnt != aw0 || ar_cnt != ar0) begin fails++; $display("FAIL bad_idx_bus: got aw=%0d ar=%0d want aw=%0d ar=%0d", aw_cnt, ar_cnt, aw0, ar0); end
    tests++; if (cfg_err !== 1'b1) begin fails++; $display("FAIL bad_idx_cfg_err: got %b want 1", cfg_err); end
  endtask

  task automatic test_slow_slave;
    int awc = 0, wc = 0, bad = 0, t = 0;
    logic done = 1'b0, er = 1'bX;
    aw_dly = 3; w_dly = 5; bresp_cfg = 2'b10;
    req_wr[0] = 1'b1; req_idx[0] = 3'd3; req_wdata[0] = 32'h12345678; req_valid[0] = 1'b1;
    while (!done && t < 100) begin
      @(negedge clk); t++;
      if (req_ready[0]) req_valid[0] = 1'b0;
      if (axi.awvalid) begin awc++; if (axi.awaddr !== 32'h0000000C) bad++; end
      if (axi.wvalid) begin wc++; if (axi.wdata !== 32'h12345678 || axi.wstrb !== 4'hF) bad++; end
      if (rsp_valid[0]) begin done = 1'b1; er = rsp_err[0]; end
    end
    req_valid[0] = 1'b0; rsp_ready[0] = 1'b1;
    @(negedge clk); rsp_ready[0] = 1'b0;
    aw_dly = 0; w_dly = 0; bresp_cfg = 2'b00;
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL slow_rsp: got timeout want response"); end
    tests++; if (awc != 4) begin fails++; $display("FAIL slow_awvalid_cycles: got %0d want 4", awc); end
    tests++; if (wc != 6) begin fails++; $display("FAIL slow_wvalid_cycles: got %0d want 6", wc); end
    tests++; if (bad != 0) begin fails++; $display("FAIL slow_hold: got %0d unstable cycles want 0", bad); end
    tests++; if (er !== 1'b1) begin fails++; $display("FAIL slow_err: got %b want 1", er); end
  endtask

`ifdef MAC_CFG_READBACK_VERIFY_EN
  task automatic test_verify;
    logic [31:0] rd; logic er, ok;
    corrupt = 1'b1;
    do_req(0, 1'b1, 3'd5, 32'hA5A5A5A5, rd, er, ok);
    corrupt = 1'b0;
    tests++; if ({ok, er} !== 2'b11) begin fails++; $display("FAIL verify_err: got ok=%b err=%b want ok=1 err=1", ok, er); end
  endtask
`endif

  task automatic test_reset_mid;
    logic [12:0] ctl;
    int t = 0;
    req_wr[0] = 1'b1; req_idx[0] = 3'd0; req_wdata[0] = 32'h00000055; req_valid[0] = 1'b1;
    while (!axi.bready && t < 50) begin
      @(negedge clk); t++;
      if (req_ready[0]) req_valid[0] = 1'b0;
    end
    tests++; if (axi.bready !== 1'b1) begin fails++; $display("FAIL mid_reach_wr_rsp: got bready=%b want 1", axi.bready); end
    rst = 1'b1; req_valid[0] = 1'b0;
    @(negedge clk);
    ctl = {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready, req_ready, rsp_valid, rsp_err, boot_done, cfg_err};
    tests++; if (ctl !== 13'd0) begin fails++; $display("FAIL mid_reset_outputs: got %h want 0", ctl); end
    rst = 1'b0;
    t = 0;
    while (!axi.awvalid && t < 20) begin @(negedge clk); t++; end
    tests++; if ({axi.awvalid, axi.awaddr, axi.wdata} !== {1'b1, 32'h0, 32'hDDCCBBAA}) begin
      fails++; $display("FAIL mid_reboot_first: got v=%b addr=%h data=%h want v=1 addr=0 data=ddccbbaa", axi.awvalid, axi.awaddr, axi.wdata);
    end
    t = 0;
    while (!boot_done && t < 300) begin @(negedge clk); t++; end
    tests++; if ({boot_done, cfg_err} !== 2'b10) begin fails++; $display("FAIL mid_reboot_done: got done=%b err=%b want done=1 err=0", boot_done, cfg_err); end
  endtask

  initial begin
    test_reset;
    test_boot;
    test_write_read;
    test_back_to_back;
    test_bad_idx;
    test_slow_slave;
`ifdef MAC_CFG_READBACK_VERIFY_EN
    test_verify;
`endif
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
